aes_decipher_block: RTL



---
 rtl/aes_decipher_block.sv | 137 +++++++++++++
 1 files changed

// File: rtl/aes_decipher_block.sv
// aes_decipher_block: iterative AES-128/256 inverse cipher, one round per clock.
// Round keys are fetched from an external key memory indexed by the round output.
module aes_inv_sbox (
  input  logic [7:0] addr,
  output logic [7:0] data
);
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  logic [7:0] b, sq, acc;
  // inverse affine transform, then multiplicative inverse as b^254 (maps 0 to 0)
  always_comb begin
    b = {addr[6:0], addr[7]} ^ {addr[4:0], addr[7:5]} ^ {addr[1:0], addr[7:2]} ^ 8'h05;
    sq = b;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gm(sq, sq);
      acc = gm(acc, sq);
    end
    data = acc;
  end
endmodule

module aes_decipher_block #(
  parameter int AES_128_NUM_ROUNDS = 10,
  parameter int AES_256_NUM_ROUNDS = 14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  input  logic [127:0] block,
  input  logic [127:0] round_key,
  output logic [3:0]   round,
  output logic         ready,
  output logic [127:0] new_block
);
  typedef enum logic [1:0] {CTRL_IDLE, CTRL_INIT, CTRL_MAIN} ctrl_t;
  ctrl_t ctrl_reg, ctrl_new;
  logic [127:0] state_reg, state_new, sub, ark, mix;
  logic [3:0] round_reg, round_new;
  logic ready_reg, ready_new;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // byte s[r][c] lives at bits [8*(15-4c-r) +: 8]; row r rotates right by r
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[8*(15-4*c-r) +: 8] = s[8*(15-4*((c-r+4)%4)-r) +: 8];
    return t;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] m;
    logic [7:0] a0, a1, a2, a3;
    m = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[32*(3-c) +: 32];
      m[32*(3-c) +: 32] = {
        gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09),
        gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d),
        gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b),
        gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e)};
    end
    return m;
  endfunction

  // InvSubBytes is applied before InvShiftRows; the two commute
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (.addr(state_reg[8*i +: 8]), .data(sub[8*i +: 8]));
  end

  assign ark = inv_shift_rows(sub) ^ round_key;
  assign mix = inv_mix_columns(ark);
  assign round = round_reg;
  assign ready = ready_reg;
  assign new_block = state_reg;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ctrl_reg <= CTRL_IDLE;
      state_reg <= '0;
      round_reg <= '0;
      ready_reg <= 1'b1;
    end else begin
      ctrl_reg <= ctrl_new;
      state_reg <= state_new;
      round_reg <= round_new;
      ready_reg <= ready_new;
    end

  always_comb begin
    ctrl_new = ctrl_reg;
    state_new = state_reg;
    round_new = round_reg;
    ready_new = ready_reg;
    case (ctrl_reg)
      CTRL_IDLE: if (next) begin
        state_new = block;
        round_new = keylen ? 4'(AES_256_NUM_ROUNDS) : 4'(AES_128_NUM_ROUNDS);
        ready_new = 1'b0;
        ctrl_new = CTRL_INIT;
      end
      CTRL_INIT: begin
        state_new = state_reg ^ round_key;
        round_new = round_reg - 4'd1;
        ctrl_new = CTRL_MAIN;
      end
      CTRL_MAIN: begin
        state_new = (round_reg != 4'd0) ? mix : ark;
        round_new = (round_reg != 4'd0) ? round_reg - 4'd1 : 4'd0;
        ready_new = (round_reg == 4'd0);
        ctrl_new = (round_reg == 4'd0) ? CTRL_IDLE : CTRL_MAIN;
      end
      default: ctrl_new = CTRL_IDLE;
    endcase
  end
endmodule
